// File: rtl/qr_back_substitution_if.sv
// Handshake and data bundle for qr_back_substitution: Q, R, b in; x, singular, residual out.
interface qr_back_substitution_if #(
    parameter int unsigned M = 3,
    parameter int unsigned N = 3
);
    logic in_valid;
    logic in_ready;
    real  q [M][N];
    real  r [N][N];
    real  b [M];
    logic out_valid;
    logic out_ready;
    real  x [N];
    logic singular;
    real  residual;

    modport master (
        output in_valid, q, r, b, out_ready,
        input  in_ready, out_valid, x, singular, residual
    );

    modport slave (
        input  in_valid, q, r, b, out_ready,
        output in_ready, out_valid, x, singular, residual
    );
endinterface

// File: rtl/qr_back_substitution.sv
// Least-squares solve R x = Q^T b: one MAC per cycle for Q^T b, then back-substitution upward.
// Define QRBS_RESIDUAL_EN to add a RES pass accumulating sum((R x - Q^T b)^2) into residual.
module qr_back_substitution #(
    parameter int unsigned M = 3,
    parameter int unsigned N = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    qr_back_substitution_if.slave bus
);
    localparam int unsigned IW = (M > 1) ? $clog2(M) : 1;
    localparam int unsigned NW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] ILast = IW'(M - 1);
    localparam logic [NW-1:0] NLast = NW'(N - 1);

    typedef enum logic [2:0] {
        StIdle,
        StQtb,
        StBack,
        StRes,
        StDone
    } state_e;

`ifdef QRBS_RESIDUAL_EN
    localparam state_e StAfterBack = StRes;
`else
    localparam state_e StAfterBack = StDone;
`endif

    state_e r_state;
    state_e w_state_next;

    real r_qc [M][N];
    real r_rc [N][N];
    real r_bc [M];
    real r_y  [N];
    real r_x  [N];
    real r_acc;
    logic r_singular;

    logic [IW-1:0] r_i;
    logic [NW-1:0] r_k;
    logic [NW-1:0] r_row;
    logic [NW-1:0] r_j;

    logic w_in_ready;
    logic w_accept;
    logic w_qtb_last;
    logic w_row_diag;
    logic w_pass_last;
    real  w_back_in;
    real  w_back_mac;

    assign w_in_ready  = rst_n && (r_state == StIdle);
    assign w_accept    = bus.in_valid && w_in_ready;
    assign w_qtb_last  = (r_k == NLast) && (r_i == ILast);
    assign w_row_diag  = (r_j == r_row);
    assign w_pass_last = w_row_diag && (r_row == '0);

    // The first edge of each row seeds the running sum from y instead of the accumulator.
    assign w_back_in  = (r_j == NLast) ? r_y[r_row] : r_acc;
    assign w_back_mac = w_back_in - r_rc[r_row][r_j] * r_x[r_j];

`ifdef QRBS_RESIDUAL_EN
    real r_residual;
    real w_res_in;
    real w_res_mac;

    assign w_res_in  = (r_j == NLast) ? -r_y[r_row] : r_acc;
    assign w_res_mac = w_res_in + r_rc[r_row][r_j] * r_x[r_j];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: if (w_accept) w_state_next = StQtb;
            StQtb:  if (w_qtb_last) w_state_next = StBack;
            StBack: if (w_pass_last) w_state_next = StAfterBack;
            StRes:  if (w_pass_last) w_state_next = StDone;
            StDone: if (bus.out_ready) w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(M); i++) begin
                r_bc[i] <= 0.0;
                for (int k = 0; k < int'(N); k++) r_qc[i][k] <= 0.0;
            end
            for (int k = 0; k < int'(N); k++) begin
                r_y[k] <= 0.0;
                r_x[k] <= 0.0;
                for (int j = 0; j < int'(N); j++) r_rc[k][j] <= 0.0;
            end
            r_acc      <= 0.0;
            r_singular <= 1'b0;
            r_i        <= '0;
            r_k        <= '0;
            r_row      <= '0;
            r_j        <= '0;
`ifdef QRBS_RESIDUAL_EN
            r_residual <= 0.0;
`endif
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (w_accept) begin
                        for (int i = 0; i < int'(M); i++) begin
                            r_bc[i] <= bus.b[i];
                            for (int k = 0; k < int'(N); k++) r_qc[i][k] <= bus.q[i][k];
                        end
                        for (int k = 0; k < int'(N); k++) begin
                            r_y[k] <= 0.0;
                            r_x[k] <= 0.0;
                            for (int j = 0; j < int'(N); j++) r_rc[k][j] <= bus.r[k][j];
                        end
                        r_singular <= 1'b0;
                        r_i        <= '0;
                        r_k        <= '0;
`ifdef QRBS_RESIDUAL_EN
                        r_residual <= 0.0;
`endif
                    end
                end
                StQtb: begin
                    r_y[r_k] <= r_y[r_k] + r_qc[r_i][r_k] * r_bc[r_i];
                    if (w_qtb_last) begin
                        r_i   <= '0;
                        r_k   <= '0;
                        r_row <= NLast;
                        r_j   <= NLast;
                    end else if (r_i == ILast) begin
                        r_i <= '0;
                        r_k <= r_k + 1'b1;
                    end else begin
                        r_i <= r_i + 1'b1;
                    end
                end
                StBack: begin
                    if (w_row_diag) begin
                        // A zero pivot leaves x[row] at zero and flags the solve; later rows go on.
                        if (r_rc[r_row][r_row] == 0.0) begin
                            r_x[r_row] <= 0.0;
                            r_singular <= 1'b1;
                        end else begin
                            r_x[r_row] <= w_back_in / r_rc[r_row][r_row];
                        end
                        r_row <= (r_row == '0) ? NLast : r_row - 1'b1;
                        r_j   <= NLast;
                    end else begin
                        r_acc <= w_back_mac;
                        r_j   <= r_j - 1'b1;
                    end
                end
`ifdef QRBS_RESIDUAL_EN
                StRes: begin
                    if (w_row_diag) begin
                        r_residual <= r_residual + w_res_mac * w_res_mac;
                        r_row      <= (r_row == '0) ? NLast : r_row - 1'b1;
                        r_j        <= NLast;
                    end else begin
                        r_acc <= w_res_mac;
                        r_j   <= r_j - 1'b1;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = (r_state == StDone);
    assign bus.x         = r_x;
    assign bus.singular  = r_singular;
`ifdef QRBS_RESIDUAL_EN
    assign bus.residual  = r_residual;
`else
    assign bus.residual  = 0.0;
`endif

endmodule

// File: tb/tb_qr_back_substitution.sv
// Scoreboard bench for qr_back_substitution: a 3x3 and a 4x2 instance against a plain-math model.
module tb_qr_back_substitution;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

`ifdef QRBS_RESIDUAL_EN
    localparam int Lat3 = 21;
    localparam int Lat2 = 14;
`else
    localparam int Lat3 = 15;
    localparam int Lat2 = 11;
`endif

    qr_back_substitution_if #(.M(3), .N(3)) bus ();
    qr_back_substitution_if #(.M(4), .N(2)) bus2 ();

    qr_back_substitution #(.M(3), .N(3)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    qr_back_substitution #(.M(4), .N(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int done_cnt = 0;
    int done2_cnt = 0;
    int hold_req = -1;

    real sb_x[$];
    bit  sb_sing[$];
    real sb_res[$];
    int  sb_acc[$];
    real sb2_x[$];
    bit  sb2_sing[$];
    real sb2_res[$];
    int  sb2_acc[$];

    real m_q [4][3];
    real m_r [3][3];
    real m_b [4];
    real m_x [3];
    bit  m_sing;
    real m_res;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk_bit(input string nm, input logic a, input logic e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s: got %0b expected %0b", nm, a, e);
        end
    endtask

    task automatic chk_int(input string nm, input int a, input int e);
        checks++;
        if (a != e) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, a, e);
        end
    endtask

    task automatic chk_real(input string nm, input real a, input real e);
        real tol;
        tol = 1e-9 * (1.0 + ((e < 0.0) ? -e : e));
        checks++;
        if ((a - e > tol) || (e - a > tol)) begin
            failures++;
            $display("FAIL %s: got %g expected %g", nm, a, e);
        end
    endtask

    // Reference: y = Q^T b, then x[row] = (y[row] - sum_{j>row} R[row][j] x[j]) / R[row][row].
    task automatic model(input int m, input int n);
        real y[3];
        real s;
        for (int k = 0; k < 3; k++) begin
            y[k] = 0.0;
            m_x[k] = 0.0;
        end
        for (int k = 0; k < n; k++)
            for (int i = 0; i < m; i++) y[k] += m_q[i][k] * m_b[i];
        m_sing = 1'b0;
        for (int row = n - 1; row >= 0; row--) begin
            s = y[row];
            for (int j = row + 1; j < n; j++) s -= m_r[row][j] * m_x[j];
            if (m_r[row][row] == 0.0) begin
                m_x[row] = 0.0;
                m_sing = 1'b1;
            end else begin
                m_x[row] = s / m_r[row][row];
            end
        end
        m_res = 0.0;
`ifdef QRBS_RESIDUAL_EN
        for (int row = 0; row < n; row++) begin
            s = -y[row];
            for (int j = row; j < n; j++) s += m_r[row][j] * m_x[j];
            m_res += s * s;
        end
`endif
    endtask

    function automatic real rnd_val();
        return real'($urandom_range(0, 32)) / 4.0 - 4.0;
    endfunction

    task automatic randomize_mats(input int m, input int n);
        for (int i = 0; i < 4; i++) begin
            m_b[i] = rnd_val();
            for (int k = 0; k < 3; k++) m_q[i][k] = rnd_val();
        end
        for (int k = 0; k < 3; k++)
            for (int j = 0; j < 3; j++) m_r[k][j] = rnd_val();
        for (int k = 0; k < n; k++) begin
            if ($urandom_range(0, 5) == 0) m_r[k][k] = 0.0;
            else m_r[k][k] = ($urandom_range(0, 1) ? 1.0 : -1.0)
                             * real'($urandom_range(4, 20)) / 4.0;
        end
        model(m, n);
    endtask

    task automatic send3();
        int t = 0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            bus.b[i] = m_b[i];
            for (int k = 0; k < 3; k++) begin
                bus.q[i][k] = m_q[i][k];
                bus.r[i][k] = m_r[i][k];
            end
        end
        bus.in_valid = 1'b1;
        while (!bus.in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!bus.in_ready) begin
            chk_bit("accept_timeout", bus.in_ready, 1'b1);
            bus.in_valid = 1'b0;
            return;
        end
        for (int k = 0; k < 3; k++) sb_x.push_back(m_x[k]);
        sb_sing.push_back(m_sing);
        sb_res.push_back(m_res);
        sb_acc.push_back(cyc + 1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        // Captured copies must be used from here on; disturb the live inputs.
        for (int i = 0; i < 3; i++) begin
            bus.b[i] = rnd_val();
            bus.q[i][0] = rnd_val();
            bus.r[i][i] = rnd_val();
        end
    endtask

    task automatic send2();
        int t = 0;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            bus2.b[i] = m_b[i];
            for (int k = 0; k < 2; k++) bus2.q[i][k] = m_q[i][k];
        end
        for (int k = 0; k < 2; k++)
            for (int j = 0; j < 2; j++) bus2.r[k][j] = m_r[k][j];
        bus2.in_valid = 1'b1;
        while (!bus2.in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!bus2.in_ready) begin
            chk_bit("accept2_timeout", bus2.in_ready, 1'b1);
            bus2.in_valid = 1'b0;
            return;
        end
        for (int k = 0; k < 2; k++) sb2_x.push_back(m_x[k]);
        sb2_sing.push_back(m_sing);
        sb2_res.push_back(m_res);
        sb2_acc.push_back(cyc + 1);
        @(negedge clk);
        bus2.in_valid = 1'b0;
    endtask

    task automatic wait_done(input int target, input bit second);
        int t = 0;
        while (((second ? done2_cnt : done_cnt) < target) && t < 300) begin
            @(negedge clk);
            t++;
        end
        chk_int(second ? "done2_count" : "done_count", second ? done2_cnt : done_cnt, target);
    endtask

    // Monitor for the 3x3 instance: compares, then runs the output handshake with backpressure.
    initial begin
        bus.out_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && bus.out_valid) begin
                int hold;
                real xs[3];
                if (sb_acc.size() == 0) begin
                    chk_int("unexpected_output", 1, 0);
                end else begin
                    for (int k = 0; k < 3; k++)
                        chk_real($sformatf("x[%0d]", k), bus.x[k], sb_x.pop_front());
                    chk_bit("singular", bus.singular, sb_sing.pop_front());
                    chk_real("residual", bus.residual, sb_res.pop_front());
                    chk_int("latency", cyc - sb_acc.pop_front(), Lat3);
                end
                hold = (hold_req >= 0) ? hold_req : int'($urandom_range(0, 3));
                hold_req = -1;
                for (int k = 0; k < 3; k++) xs[k] = bus.x[k];
                for (int h = 0; h < hold; h++) begin
                    @(negedge clk);
                    chk_bit("hold_valid", bus.out_valid, 1'b1);
                    chk_bit("hold_in_ready", bus.in_ready, 1'b0);
                    chk_bit("hold_x_stable", (bus.x[0] == xs[0]) && (bus.x[1] == xs[1])
                                             && (bus.x[2] == xs[2]), 1'b1);
                end
                bus.out_ready = 1'b1;
                @(negedge clk);
                bus.out_ready = 1'b0;
                chk_bit("release_valid", bus.out_valid, 1'b0);
                chk_bit("release_in_ready", bus.in_ready, 1'b1);
                done_cnt++;
            end
        end
    end

    // Monitor for the 4x2 instance: always ready, so out_valid lasts one cycle.
    initial begin
        bus2.out_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (rst_n && bus2.out_valid) begin
                if (sb2_acc.size() == 0) begin
                    chk_int("unexpected_output2", 1, 0);
                end else begin
                    for (int k = 0; k < 2; k++)
                        chk_real($sformatf("x2[%0d]", k), bus2.x[k], sb2_x.pop_front());
                    chk_bit("singular2", bus2.singular, sb2_sing.pop_front());
                    chk_real("residual2", bus2.residual, sb2_res.pop_front());
                    chk_int("latency2", cyc - sb2_acc.pop_front(), Lat2);
                end
                done2_cnt++;
            end
        end
    end

    initial begin
        int n3 = 0;
        int n2 = 0;
        bus.in_valid = 1'b0;
        bus2.in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            m_b[i] = 0.0;
            for (int k = 0; k < 3; k++) m_q[i][k] = 0.0;
        end
        for (int i = 0; i < 3; i++) begin
            bus.b[i] = 0.0;
            for (int k = 0; k < 3; k++) begin
                bus.q[i][k] = 0.0;
                bus.r[i][k] = 0.0;
            end
        end

        // Reset state
        #12;
        chk_bit("rst_in_ready", bus.in_ready, 1'b0);
        chk_bit("rst_out_valid", bus.out_valid, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk_bit("idle_in_ready", bus.in_ready, 1'b1);
        chk_bit("idle_singular", bus.singular, 1'b0);
        chk_real("idle_residual", bus.residual, 0.0);
        for (int k = 0; k < 3; k++) chk_real("idle_x", bus.x[k], 0.0);

        // Basic 3x3 solve with hand-computed answer
        for (int i = 0; i < 3; i++)
            for (int k = 0; k < 3; k++) m_q[i][k] = (i == k) ? 1.0 : 0.0;
        m_r[0][0] = 2.0; m_r[0][1] = 1.0; m_r[0][2] = 0.0;
        m_r[1][0] = 9.0; m_r[1][1] = 4.0; m_r[1][2] = 2.0;
        m_r[2][0] = 7.0; m_r[2][1] = -3.0; m_r[2][2] = 5.0;
        m_b[0] = 3.0; m_b[1] = 10.0; m_b[2] = 10.0;
        m_x[0] = 0.75; m_x[1] = 1.5; m_x[2] = 2.0;
        m_sing = 1'b0;
        m_res = 0.0;
        send3();
        n3++;
        wait_done(n3, 1'b0);

        // Singular pivot on row 1
        m_r[1][1] = 0.0;
        m_x[0] = 1.5; m_x[1] = 0.0; m_x[2] = 2.0;
        m_sing = 1'b1;
`ifdef QRBS_RESIDUAL_EN
        m_res = 36.0;
`else
        m_res = 0.0;
`endif
        send3();
        n3++;
        wait_done(n3, 1'b0);

        // Tall 4x2: Q columns e0, e1; R = I
        for (int i = 0; i < 4; i++)
            for (int k = 0; k < 3; k++) m_q[i][k] = (i == k) ? 1.0 : 0.0;
        for (int k = 0; k < 3; k++)
            for (int j = 0; j < 3; j++) m_r[k][j] = (k == j) ? 1.0 : 0.0;
        m_b[0] = 1.0; m_b[1] = 2.0; m_b[2] = 7.0; m_b[3] = 7.0;
        m_x[0] = 1.0; m_x[1] = 2.0; m_x[2] = 0.0;
        m_sing = 1'b0;
        m_res = 0.0;
        send2();
        n2++;
        wait_done(n2, 1'b1);

        // Backpressure: hold 5 cycles and offer a stray input that must be ignored
        randomize_mats(3, 3);
        hold_req = 5;
        send3();
        n3++;
        begin
            int t = 0;
            while (!bus.out_valid && t < 100) begin
                @(negedge clk);
                t++;
            end
            chk_bit("bp_out_valid_seen", bus.out_valid, 1'b1);
        end
        @(negedge clk);
        bus.in_valid = 1'b1;
        repeat (3) @(negedge clk);
        bus.in_valid = 1'b0;
        wait_done(n3, 1'b0);

        // Reset during QTB, four edges after accept
        randomize_mats(3, 3);
        send3();
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_bit("midrst_out_valid", bus.out_valid, 1'b0);
        chk_bit("midrst_in_ready", bus.in_ready, 1'b0);
        chk_bit("midrst_singular", bus.singular, 1'b0);
        for (int k = 0; k < 3; k++) chk_real("midrst_x", bus.x[k], 0.0);
        if (sb_acc.size() > 0) begin
            for (int k = 0; k < 3; k++) void'(sb_x.pop_back());
            void'(sb_sing.pop_back());
            void'(sb_res.pop_back());
            void'(sb_acc.pop_back());
        end
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized solves on both instances
        for (int t = 0; t < 20; t++) begin
            randomize_mats(3, 3);
            send3();
            n3++;
            wait_done(n3, 1'b0);
        end
        for (int t = 0; t < 8; t++) begin
            randomize_mats(4, 2);
            send2();
            n2++;
            wait_done(n2, 1'b1);
        end

        repeat (40) @(negedge clk);
        chk_int("sb_empty", sb_acc.size(), 0);
        chk_int("sb2_empty", sb2_acc.size(), 0);
        chk_int("final_done", done_cnt, n3);
        chk_int("final_done2", done2_cnt, n2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/qr_back_substitution.md
Name: qr_back_substitution

Overview:
- Downstream consumer of the QR decomposition stage. Takes Q (M x N), R (N x N) and a right-hand-side vector b (M), and solves the least-squares system R x = Q^T b.
- Sequential datapath with one real multiply-accumulate per cycle, then back-substitution from the last row upward.
- Valid/ready handshake on both input and output so it can be chained in the test-bench model pipeline.

Parameters:
- M, 3, rows of Q and length of b; M >= N is required and not checked.
- N, 3, columns of Q, size of R, length of x.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  Q, R, b are valid.
- in_ready  output  1  block can accept; equals rst_n AND (state == IDLE).
- Q  input  real[M][N]  orthonormal factor.
- R  input  real[N][N]  upper-triangular factor; the strictly-lower part is ignored.
- b  input  real[M]  right-hand side.
- out_valid  output  1  x is valid; held until accepted.
- out_ready  input  1  downstream accepts x.
- x  output  real[N]  solution vector.
- singular  output  1  a zero diagonal of R was encountered in this solve.
- residual  output  real  sum of squares of (R x - Q^T b); see Optional Feature.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE; out_valid = 0; singular = 0; residual = 0.0.
  - x, the internal y[N] and all captured copies are cleared to 0.0.
  - Asserting reset mid-operation aborts the current solve immediately; no output is produced for it.
- States: IDLE, QTB, BACK, RES (feature only), DONE.
- IDLE:
  - On an edge with in_valid & in_ready, capture Q, R, b into internal registers.
  - Clear y, x and singular; go to QTB with k = 0, i = 0.
  - Inputs are not sampled after capture.
- QTB: one MAC per edge, y[k] += Qc[i][k] * bc[i].
  - i counts 0..M-1 and wraps to 0 while k increments.
  - After the MAC with k = N-1, i = M-1, go to BACK with row = N-1, j = N-1.
  - Takes exactly M*N edges.
- BACK, per row (row counts N-1 down to 0):
  - For j = N-1 down to row+1, one MAC per edge: acc -= Rc[row][j] * x[j]. acc is initialised to y[row] on row entry.
  - Then one divide edge: x[row] = acc / Rc[row][row].
  - If Rc[row][row] == 0.0: x[row] = 0.0, singular = 1, and the solve continues.
  - Row N-1 therefore takes 1 edge and row 0 takes N edges; the whole state takes N(N+1)/2 edges.
  - After row 0 go to DONE, or to RES if the feature is enabled.
- DONE:
  - out_valid = 1; x, singular and residual are held stable.
  - On an edge with out_ready high: out_valid = 0, go to IDLE.
  - in_ready stays low throughout DONE, so there is no accept on the same edge as the output handshake.
- Latency: out_valid rises exactly M*N + N(N+1)/2 edges after the accept edge (15 for 3x3). With the feature enabled, add N(N+1)/2.
- Throughput: at most one solve in flight. Minimum initiation interval is latency + 2 edges.
- Arithmetic: IEEE real throughout; no rounding or saturation. Division occurs only in the divide edge.
- in_valid while in_ready is low is ignored and does not affect the current solve.

Optional Feature:
- Macro QRBS_RESIDUAL_EN.
- Defined:
  - RES state after BACK, N(N+1)/2 edges, one MAC per edge over the upper triangle.
  - Per row, e = sum_{j>=row} Rc[row][j] * x[j] - y[row]; then residual += e*e.
  - On exit go to DONE.
- Undefined:
  - No RES state; residual is constant 0.0.
  - Latency is as stated without the extra N(N+1)/2 term.

Test Plan:
- Basic solve, M=N=3. Q = I, R = [[2,1,0],[0,4,2],[0,0,5]], b = [3,10,10] -> x = [0.75, 1.5, 2.0], singular = 0. out_valid rises 15 edges after accept.
- Tall case, M=4, N=2. Q columns e0 and e1, R = I, b = [1,2,7,7] -> x = [1,2]. Latency 11.
- Singular: same as the basic solve but R[1][1] = 0 -> singular = 1, x[1] = 0.0, x[2] = 2.0. Solve completes with normal latency.
- Backpressure: out_ready held low for 5 cycles after out_valid -> x stable and in_ready = 0. A new in_valid during this time is ignored. Release -> in_ready = 1 on the next edge.
- Reset mid-solve: drop rst_n during QTB (edge 4) -> out_valid = 0 and x = 0 immediately. After release, a new solve gives the correct result.
- With QRBS_RESIDUAL_EN, basic 3x3 solve -> residual = 0.0 within 1e-12, latency 21. Without the macro, residual = 0.0 and latency 15.
